// File: rtl/classify_argmax_pkg.sv
// Shared constants and FSM encoding for the output-stage argmax classifier.
// Widths match the gSRAM Q8.8 score format and its row/column address lines.
package classify_argmax_pkg;

    localparam int Q88_W         = 16;
    localparam int GSRAM_ADDR_W  = 4;
    localparam int DEF_N_CLASSES = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/classify_argmax_cmp.sv
// Running signed maximum with index; first qualified sample loads unconditionally.
// Latency: running max registered one cycle after a qualified sample; next value exposed combinationally.
// No backpressure: a sample is consumed every cycle smp_vld is high.
module argmax_cmp
    import classify_argmax_pkg::*;
#(
    parameter int DATA_W = Q88_W,
    parameter int IDX_W  = GSRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              smp_vld,
    input  logic [DATA_W-1:0] smp_dat,
    input  logic [IDX_W-1:0]  smp_idx,
    output logic [DATA_W-1:0] max_nxt_dat,
    output logic [IDX_W-1:0]  max_nxt_idx
);

    logic              first_q;
    logic [DATA_W-1:0] max_q;
    logic [IDX_W-1:0]  idx_q;
    logic              take;

    // Strict greater-than keeps the earlier (lower) index on ties.
    always_comb begin
        take        = smp_vld && (first_q || ($signed(smp_dat) > $signed(max_q)));
        max_nxt_dat = take ? smp_dat : max_q;
        max_nxt_idx = take ? smp_idx : idx_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_q <= 1'b0;
            max_q   <= '0;
            idx_q   <= '0;
        end else if (clr) begin
            first_q <= 1'b1;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            if (smp_vld) begin
                first_q <= 1'b0;
            end
            max_q <= max_nxt_dat;
            idx_q <= max_nxt_idx;
        end
    end

endmodule

// File: rtl/classify_argmax.sv
// Reads N_CLASSES signed Q8.8 scores from the result row and reports the argmax.
// Latency: done pulses N_CLASSES+2 cycles after an accepted start.
// No backpressure: start is ignored unless idle; the gSRAM returns data one cycle after address.
module classify_argmax
    import classify_argmax_pkg::*;
#(
    parameter int N_CLASSES  = DEF_N_CLASSES,
    parameter int DATA_W     = Q88_W,
    parameter int ADDR_W     = GSRAM_ADDR_W,
    parameter int RESULT_ROW = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_row,
    output logic [ADDR_W-1:0] rd_col,
    input  logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [ADDR_W-1:0] class_idx,
    output logic [DATA_W-1:0] class_val
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(N_CLASSES - 1);

    state_t            state;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_tag_q;
    logic              clr;
    logic [DATA_W-1:0] max_nxt_dat;
    logic [ADDR_W-1:0] max_nxt_idx;

    assign rd_row = ADDR_W'(RESULT_ROW);
    assign clr    = (state == ST_IDLE) && start;

    // rd_col doubles as the column counter and is parked at 0 outside READ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            rd_req    <= 1'b0;
            rd_col    <= '0;
            done      <= 1'b0;
            class_idx <= '0;
            class_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= ST_READ;
                        busy   <= 1'b1;
                        rd_req <= 1'b1;
                        rd_col <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_col == LAST_COL) begin
                        state  <= ST_DRAIN;
                        rd_req <= 1'b0;
                        rd_col <= '0;
                    end else begin
                        rd_col <= rd_col + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The last sample is compared this cycle, so take the next-state max.
                    state     <= ST_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    class_idx <= max_nxt_idx;
                    class_val <= max_nxt_dat;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_q <= 1'b0;
            rd_tag_q <= '0;
        end else begin
            rd_vld_q <= rd_req;
            rd_tag_q <= rd_col;
        end
    end

    argmax_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (ADDR_W)
    ) u_cmp (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .smp_vld     (rd_vld_q),
        .smp_dat     (rd_data),
        .smp_idx     (rd_tag_q),
        .max_nxt_dat (max_nxt_dat),
        .max_nxt_idx (max_nxt_idx)
    );

endmodule

// File: tb/tb_classify_argmax.sv
// Randomized scoreboard bench for classify_argmax against a plain argmax reference model.
module tb_classify_argmax;

    localparam int N = 10;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, rd_req, done;
    logic [3:0]  rd_row, rd_col, class_idx;
    logic [15:0] rd_data, class_val;

    logic [15:0] mem [16];
    exp_t        q[$];
    int          cyc = 0;
    int          run_start = -1;
    logic [3:0]  held_idx = '0;
    logic [15:0] held_val = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    classify_argmax #(
        .N_CLASSES  (N),
        .DATA_W     (16),
        .ADDR_W     (4),
        .RESULT_ROW (0)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .busy      (busy),
        .rd_req    (rd_req),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data),
        .done      (done),
        .class_idx (class_idx),
        .class_val (class_val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // gSRAM: registered read; junk on the bus when not requested.
    always @(posedge clk) rd_data <= rd_req ? mem[rd_col] : 16'($urandom);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", nm, cyc, act, req);
        end
    endtask

    // Reference: strict signed argmax, lowest index kept on ties.
    function automatic exp_t ref_model(input int at_cyc);
        exp_t e;
        int best = 0;
        for (int i = 1; i < N; i++)
            if ($signed(mem[i]) > $signed(mem[best])) best = i;
        e.idx = 4'(best);
        e.val = mem[best];
        e.cyc = at_cyc + N + 2;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        q.push_back(ref_model(cyc));
        run_start = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < N + 6 && q.size() != 0; i++) tick();
        chk("done_seen", q.size(), 0);
        q.delete();
        run_start = -1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_rd_col"}, rd_col, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_class_idx"}, class_idx, 0);
        chk({tag, "_class_val"}, class_val, 0);
    endtask

    // Monitor: per-cycle timing model plus scoreboard pop on done.
    always @(negedge clk) begin
        int   k;
        bit   act, exp_req, exp_busy;
        exp_t e;
        act      = (run_start >= 0);
        k        = cyc - run_start;
        exp_req  = act && k >= 1 && k <= N;
        exp_busy = act && k >= 1 && k <= N + 1;
        chk("busy", busy, 32'(exp_busy));
        chk("rd_req", rd_req, 32'(exp_req));
        chk("rd_col", rd_col, exp_req ? 32'(k - 1) : 32'd0);
        chk("rd_row", rd_row, 0);
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("class_idx", class_idx, e.idx);
                chk("class_val", class_val, e.val);
                held_idx = e.idx;
                held_val = e.val;
            end
        end else begin
            chk("hold_idx", class_idx, held_idx);
            chk("hold_val", class_val, held_val);
            if (q.size() != 0 && cyc >= q[0].cyc) begin
                chk("done_pulse", done, 1);
                void'(q.pop_front());
            end
        end
        if (act && k >= N + 2) run_start = -1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Ascending scores
        for (int i = 0; i < N; i++) mem[i] = 16'((i + 1) << 8);
        start_run();
        wait_done();

        // All negative: signed compare must pick -1.0
        for (int i = 0; i < N; i++) mem[i] = 16'h8000;
        mem[3] = 16'hFF00;
        start_run();
        wait_done();

        // Tie resolves to lowest index
        for (int i = 0; i < N; i++) mem[i] = 16'h0000;
        mem[2] = 16'h0500;
        mem[7] = 16'h0500;
        start_run();
        wait_done();

        // Starts in cycle 4 and in the done cycle are ignored; cycle 13 is accepted
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(0, 16'h0FFF));
        mem[5] = 16'h1234;
        start_run();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(16'h8000, 16'hEFFF));
        mem[8] = 16'hF000;
        start_run();
        wait_done();

        // Asynchronous reset in cycle 6 aborts the run
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        start_run();
        repeat (5) tick();
        rst_n = 1'b0;
        q.delete();
        run_start = -1;
        held_idx = '0;
        held_val = '0;
        #1;
        chk_zero("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h7FFF;
        start_run();
        wait_done();

        // Randomized runs with extremes, duplicates and varying idle gaps
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       mem[i] = 16'h8000;
                    1:       mem[i] = 16'h7FFF;
                    2:       mem[i] = (i > 0) ? mem[$urandom_range(0, i - 1)] : 16'h0000;
                    default: mem[i] = 16'($urandom);
                endcase
            end
            repeat ($urandom_range(0, 3)) tick();
            start_run();
            wait_done();
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
